// File: rtl/bnn_load_sequencer.sv
// Byte-stream image loader and settle/capture sequencer for the binarized OCR core.
// Define BNN_SEQ_PERF_CNT_EN to build the completed-inference counter behind infer_count.
module bnn_load_sequencer #(
    parameter int IMG_BITS      = 904,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic                clear,
    output logic [IMG_BITS-1:0] img_out,
    input  logic [3:0]          bnn_result,
    output logic [3:0]          res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic [6:0]          byte_cnt,
    output logic [15:0]         infer_count
);

    localparam int         NBYTES      = IMG_BITS / 8;
    localparam logic [6:0] LAST_SLOT   = 7'(NBYTES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESULT = 2'd2;

    logic [1:0]          state;
    logic [7:0]          settle_cnt;
    logic [IMG_BITS-1:0] img_q;
    logic                rx_fire;
    logic                res_fire;

    assign rx_ready = (state == ST_LOAD) && !clear;
    assign rx_fire  = rx_valid && rx_ready;
    assign res_fire = res_valid && res_ready;
    assign busy     = (state != ST_LOAD);
    assign img_out  = img_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LOAD;
            byte_cnt   <= '0;
            settle_cnt <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else if (clear) begin
            state      <= ST_LOAD;
            byte_cnt   <= '0;
            settle_cnt <= '0;
            res_valid  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (rx_fire) begin
                        byte_cnt <= byte_cnt + 7'd1;
                        if (byte_cnt == LAST_SLOT) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    // Capture at the end of the window so the core output has settled.
                    if (settle_cnt == SETTLE_LAST) begin
                        res_data  <= bnn_result;
                        res_valid <= 1'b1;
                        state     <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_fire) begin
                        res_valid <= 1'b0;
                        byte_cnt  <= '0;
                        state     <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Each byte slot has its own write enable; rx_fire already excludes clear and non-LOAD states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q <= '0;
        end else begin
            for (int k = 0; k < NBYTES; k++) begin
                if (rx_fire && (byte_cnt == 7'(k)))
                    img_q[8*k +: 8] <= rx_data;
            end
        end
    end

`ifdef BNN_SEQ_PERF_CNT_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_q <= '0;
        else if (!clear && (state == ST_RESULT) && res_fire)
            perf_q <= perf_q + 16'd1;
    end

    assign infer_count = perf_q;
`else
    assign infer_count = '0;
`endif

endmodule

// File: tb/tb_bnn_load_sequencer.sv
// Randomized self-checking bench for bnn_load_sequencer against a transaction-level image/result model.
module tb_bnn_load_sequencer;

    localparam int IMG    = 904;
    localparam int NB     = IMG / 8;
    localparam int SETTLE = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     rx_data = '0;
    logic           rx_valid = 1'b0;
    logic           rx_ready;
    logic           clear = 1'b0;
    logic [IMG-1:0] img_out;
    logic [3:0]     bnn_result = '0;
    logic [3:0]     res_data;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic           busy;
    logic [6:0]     byte_cnt;
    logic [15:0]    infer_count;

    bnn_load_sequencer #(.IMG_BITS(IMG), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .clear(clear), .img_out(img_out),
        .bnn_result(bnn_result), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .byte_cnt(byte_cnt),
        .infer_count(infer_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: image bytes, fill level, remaining settle edges, pending result.
    logic [7:0]  m_img [NB];
    int          m_cnt;
    bit          m_full;
    int          m_wait;
    bit          m_rv;
    logic [3:0]  m_rd;
    logic [15:0] m_inf;

    task automatic chk(input string tag, input logic [IMG-1:0] got, input logic [IMG-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) m_img[k] = 8'h00;
        m_cnt = 0; m_full = 0; m_wait = 0; m_rv = 0; m_rd = 4'd0; m_inf = 16'd0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit c, input bit rr,
                              input logic [3:0] br);
        if (c) begin
            m_cnt = 0; m_full = 0; m_rv = 0; m_wait = 0;
        end else if (!m_full) begin
            if (v) begin
                m_img[m_cnt] = d;
                m_cnt++;
                if (m_cnt == NB) begin m_full = 1; m_wait = SETTLE; end
            end
        end else if (!m_rv) begin
            m_wait--;
            if (m_wait == 0) begin m_rv = 1; m_rd = br; end
        end else if (rr) begin
            m_rv = 0; m_full = 0; m_cnt = 0; m_inf = m_inf + 16'd1;
        end
    endtask

    function automatic logic [IMG-1:0] model_img();
        logic [IMG-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = m_img[k];
        return r;
    endfunction

    function automatic logic [15:0] exp_inf();
`ifdef BNN_SEQ_PERF_CNT_EN
        return m_inf;
`else
        return 16'd0;
`endif
    endfunction

    task automatic check_outputs();
        chk("byte_cnt", byte_cnt, m_cnt);
        chk("res_valid", res_valid, m_rv);
        chk("res_data", res_data, m_rd);
        chk("busy", busy, m_full);
        chk("img_out", img_out, model_img());
        chk("infer_count", infer_count, exp_inf());
    endtask

    task automatic do_cycle(input bit v, input logic [7:0] d, input bit c, input bit rr,
                            input logic [3:0] br);
        @(negedge clk);
        rx_valid = v; rx_data = d; clear = c; res_ready = rr; bnn_result = br;
        #1 chk("rx_ready", rx_ready, (!c && !m_full));
        @(posedge clk);
        model_step(v, d, c, rr, br);
        #1 check_outputs();
    endtask

    task automatic load_image(input logic [3:0] br);
        int budget;
        budget = 2000;
        while (!m_full && budget > 0) begin
            do_cycle(($urandom_range(0, 3) != 0), 8'($urandom), 1'b0, 1'b0, br);
            budget--;
        end
        if (!m_full) chk("load_timeout", 0, 1);
    endtask

    task automatic wait_result(input logic [3:0] br);
        int budget;
        budget = 100;
        while (!res_valid && budget > 0) begin
            do_cycle(1'b0, 8'h00, 1'b0, 1'b0, br);
            budget--;
        end
        if (!res_valid) chk("result_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", rx_ready, 1);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed stream: byte k = k, result 7.
        for (int k = 0; k < NB; k++) do_cycle(1'b1, 8'(k), 1'b0, 1'b0, 4'd7);
        chk("rdy_after_full", rx_ready, 0);
        chk("img_15_8", img_out[15:8], 8'h01);
        chk("full_cnt", byte_cnt, 113);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'd7);
            if (res_valid) begin lat = n; break; end
        end
        chk("latency", lat, 16);
        chk("res7", res_data, 7);

        // Result held under backpressure, then consumed.
        for (int n = 0; n < 50; n++) do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'($urandom));
        chk("held_valid", res_valid, 1);
        chk("held_data", res_data, 7);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
        chk("consumed_valid", res_valid, 0);
        chk("consumed_rdy", rx_ready, 1);
        chk("consumed_cnt", byte_cnt, 0);

        // Partial load aborted by clear while a byte is offered.
        for (int k = 0; k < 40; k++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 4'd0);
        do_cycle(1'b1, 8'hA5, 1'b1, 1'b0, 4'd0);
        chk("clear_cnt", byte_cnt, 0);
        load_image(4'd2);
        lat = 0;
        while (!res_valid && lat < 40) begin
            do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'd2);
            lat++;
        end
        chk("latency2", lat, 16);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);

        // Core output changes mid-window; capture must take the late value.
        load_image(4'd3);
        for (int n = 0; n < 40 && !res_valid; n++)
            do_cycle(1'b0, 8'h00, 1'b0, 1'b0, (n >= 5) ? 4'd9 : 4'd3);
        chk("late_capture", res_data, 9);
        do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);

        // Asynchronous reset in the middle of the settle window.
        load_image(4'd5);
        for (int n = 0; n < 5; n++) do_cycle(1'b0, 8'h00, 1'b0, 1'b0, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_rx_ready", rx_ready, 1);
        check_outputs();
        rst_n = 1'b1;

        // Three inferences, then clear, then reset.
        for (int i = 0; i < 3; i++) begin
            load_image(4'(i + 1));
            wait_result(4'(i + 1));
            do_cycle(1'b0, 8'h00, 1'b0, 1'b1, 4'd0);
        end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0, 4'd0);
`ifdef BNN_SEQ_PERF_CNT_EN
        chk("inf_after_clear", infer_count, 3);
`else
        chk("inf_after_clear", infer_count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("inf_after_rst", infer_count, 0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with backpressure, sporadic clear and changing core output.
        for (int n = 0; n < 3000; n++)
            do_cycle(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 1) == 1), 4'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_load_sequencer.md
# bnn_load_sequencer

Byte-stream front end and inference sequencer for the binarized OCR network. It accepts packed pixel bytes over a valid/ready stream and assembles the 904-bit image register that drives the combinational BNN core. It holds the image stable for a fixed settle window, captures the 4-bit class, and presents it over a valid/ready result handshake. It sits between the host receive path and the BNN core and replaces ad-hoc buffer-full/start strobes.

## Interface
Parameters:
- `IMG_BITS`, 904: image register width; must be a multiple of 8; core uses bits [899:0].
- `SETTLE_CYCLES`, 16: cycles the image is held before capture; legal range 1..255.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, 8: pixel byte; bit i of byte k maps to `img_out[8k+i]`.
- `rx_valid`, in, 1: `rx_data` valid.
- `rx_ready`, out, 1: byte accepted when `rx_valid && rx_ready` at a clock edge.
- `clear`, in, 1: synchronous abort; discards the partial image or pending result.
- `img_out`, out, `IMG_BITS`: image register to the BNN core.
- `bnn_result`, in, 4: combinational class from the BNN core.
- `res_data`, out, 4: captured class.
- `res_valid`, out, 1: `res_data` valid.
- `res_ready`, in, 1: result consumed when `res_valid && res_ready` at a clock edge.
- `busy`, out, 1: high in SETTLE or RESULT.
- `byte_cnt`, out, 7: bytes loaded into the current image (0..`IMG_BITS`/8).
- `infer_count`, out, 16: completed inferences (see Configuration).

## Operation
FSM states: LOAD, SETTLE, RESULT.
- **LOAD**
  - `rx_ready = !clear`.
  - On each handshake, write `rx_data` into byte slot `byte_cnt` and increment `byte_cnt`.
  - The handshake that fills the last slot (`byte_cnt == IMG_BITS/8-1`) moves the FSM to SETTLE and zeroes the settle counter. `byte_cnt` then reads `IMG_BITS/8` until the image is released.
- **SETTLE**
  - `rx_ready = 0`; `img_out` is frozen.
  - The settle counter increments every cycle.
  - On the edge where it equals `SETTLE_CYCLES-1`: `res_data <= bnn_result`, `res_valid <= 1`, FSM moves to RESULT.
- **RESULT**
  - `rx_ready = 0`; `res_data` and `res_valid` are held stable.
  - On the result handshake: `res_valid <= 0`, `byte_cnt <= 0`, FSM moves to LOAD.
- **clear** (any state, highest priority)
  - FSM moves to LOAD; `byte_cnt <= 0`; `res_valid <= 0`; settle counter is zeroed.
  - `img_out` is not erased; stale bits are overwritten by the next load.
  - A byte presented in the same cycle as `clear` is not accepted, because `rx_ready` is low.
  - A result handshake coinciding with `clear` is ignored: `res_valid` clears and `infer_count` does not increment.
- **Widths**
  - The slot index is `byte_cnt`; no wrap is possible because the FSM leaves LOAD at full.
  - Settle counter is 8 bits.

## Timing
- Reset values:
  - state = LOAD
  - `rx_ready` = 1 (when `clear` is low)
  - `img_out` = 0, `res_data` = 0, `res_valid` = 0
  - `busy` = 0, `byte_cnt` = 0, `infer_count` = 0
- `rx_ready` is combinational from state and `clear`. All other outputs are registered.
- Latency: if the last byte is accepted at edge E, then `res_valid` is high after edge E+`SETTLE_CYCLES`. `busy` is high from after edge E until the result handshake edge.
- Back-to-back images: LOAD is entered on the result-handshake edge, so `rx_ready` is high in the very next cycle.
- Reset asserted mid-operation returns all state and outputs to their reset values immediately (asynchronous). Any partial image is lost.

## Configuration
- `BNN_SEQ_PERF_CNT_EN` defined:
  - `infer_count` increments on every completed result handshake.
  - It wraps from 0xFFFF to 0x0000.
  - It is cleared only by `rst_n`, never by `clear`.
- Not defined: `infer_count` is tied to 0 and no counter logic is built.

## Test plan
- Reset, then stream 113 bytes with `rx_valid` held high, byte k = k[7:0], model `bnn_result` = 4'd7:
  - `rx_ready` falls after the 113th accept.
  - `img_out[15:8]` = 8'h01.
  - `res_valid` rises exactly 16 cycles after the last accept, with `res_data` = 7.
  - `byte_cnt` = 113.
- Hold `res_ready` low for 50 cycles, then high for one cycle:
  - `res_data` and `res_valid` stay stable through the 50 cycles.
  - `res_valid` is 0 on the next cycle; `rx_ready` = 1; `byte_cnt` = 0.
- Load 40 bytes, pulse `clear` while `rx_valid` is high:
  - That byte is not accepted; `byte_cnt` = 0.
  - A following full 113-byte load yields a result after 16 cycles.
- Change `bnn_result` from 3 to 9 mid-SETTLE (cycle 5), with `SETTLE_CYCLES` = 16: `res_data` = 9 (capture happens at end of the window).
- With `BNN_SEQ_PERF_CNT_EN`, complete 3 inferences, then pulse `clear`, then assert `rst_n` low: `infer_count` reads 3 after the clear and 0 after the reset. Without the macro, `infer_count` stays 0 throughout.
- Assert `rst_n` low during SETTLE: all outputs immediately return to reset values; `rx_ready` = 1.
